cursor_accum: RTL and testbench
===============================

Name: cursor_accum

Overview:
- Parametrised successor to the mouse-position accumulator.
- Converts signed relative mouse reports (dx, dy, buttons) into an absolute clamped screen cursor with configurable delta width, gain shift and bounds.
- Adds long-hold recentre and a board-cell lookup for the Gobang grid, computed by an iterative-subtraction FSM.
- Sits between the PS/2 mouse decoder and the game/draw logic.

Parameters:
DW, 9, delta width in bits (two's complement)
PW, 10, position width in bits (unsigned)
X_START, 320, recentre/reset X
Y_START, 240, recentre/reset Y
X_MIN, 0, lowest legal X
X_MAX, 629, highest legal X
Y_MIN, 0, lowest legal Y
Y_MAX, 469, highest legal Y
SHIFT, 1, gain: delta magnitude is right-shifted by SHIFT
RECENTER_BTN, 3, button pattern that arms recentre
HOLD_CNT, 3, consecutive accepted reports with RECENTER_BTN that trigger recentre (≥1)
BOARD_X0, 95, board origin X
BOARD_Y0, 15, board origin Y
CELL, 30, cell pitch in pixels
N_CELLS, 15, cells per axis; CW = clog2(N_CELLS)

Ports:
clk  in  1  clock
rst_p  in  1  synchronous reset, active-high
valid_i  in  1  report strobe, one cycle
dx_i  in  DW  signed X delta
dy_i  in  DW  signed Y delta (positive = increasing Y)
btn_i  in  8  button bits; bit0 = left
pos_x  out  PW  cursor X
pos_y  out  PW  cursor Y
cell_x  out  CW  board column of cursor
cell_y  out  CW  board row of cursor
in_board_o  out  1  cursor lies inside the board
click_o  out  1  left-button rising edge, coincident with valid_o
btn_o  out  8  buttons of the last accepted report
valid_o  out  1  one-cycle pulse: all outputs updated
drop_o  out  1  one-cycle pulse: valid_i arrived while busy

Behaviour:
- Reset (sync, rst_p high at posedge):
  - pos = (X_START, Y_START); cell/in_board computed for the start point are NOT required, and cell = 0, in_board_o = 0.
  - click_o, valid_o, drop_o, btn_o, hold counter and previous-button register = 0.
  - FSM = IDLE.
  - Reset mid-operation aborts any calculation; no valid_o is issued.
- FSM states: IDLE, ACC, CELL, DONE.
  - IDLE: valid_i accepted. dx, dy and btn are captured; click is computed as btn_i[0] & ~prev_btn0; prev_btn0 is updated. Go to ACC.
  - ACC, one cycle: update pos. Load the CELL iterators. Go to CELL.
  - CELL: one subtraction per axis per cycle, both axes in parallel. Go to DONE when both axes have finished.
  - DONE: valid_o = 1 and click_o = captured click for this cycle; btn_o updated. Return to IDLE.
- valid_i in any state other than IDLE: report discarded, drop_o pulses in the same cycle. This also applies to DONE; a report in the IDLE cycle after DONE is accepted.
- Latency: pos updates at the end of ACC, i.e. visible 2 cycles after the accept edge. valid_o arrives 3 + k cycles after the accept edge, where k = max(cell_x, cell_y) + 1, or k = 1 when the cursor is outside the board. Maximum is N_CELLS + 3.
- Arithmetic:
  - scaled = sign(d) · (|d| >> SHIFT). Truncation is toward zero, so -1 → 0 with SHIFT = 1.
  - |−2^(DW−1)| is representable; evaluate in DW+1 bits.
  - next = pos + scaled, evaluated signed in PW+2 bits, then clamped: next < MIN → MIN, next > MAX → MAX.
  - No wrap-around at any extreme delta.
- Recentre:
  - An accepted report with btn_i == RECENTER_BTN increments the hold counter (saturating); any other pattern clears it.
  - When the increment reaches HOLD_CNT, ACC loads (X_START, Y_START) instead of the accumulated value and clears the counter. Deltas of that report are ignored.
- Cell lookup, per axis:
  - If pos < ORIGIN or pos − ORIGIN ≥ CELL·N_CELLS: in_board = 0 for that axis, cell = 0, and the axis is done after 1 CELL cycle.
  - Otherwise, starting from rel = pos − ORIGIN, repeat: if rel ≥ CELL then rel −= CELL and count++; else done.
  - in_board_o = X in-board AND Y in-board.
  - cell_x, cell_y and in_board_o hold their values between valid_o pulses.

Test Plan:
- Reset, then dx = +20, dy = −10, SHIFT = 1 → pos = (330, 235), valid_o 2+ cycles later. in_board_o = 1, cell = (7, 7); 235 − 15 = 220 gives 220/30 = 7.
- Saturation: dx = +255 repeated 3×, then dx = −256 once, all at SHIFT = 0 from X = 320 → pos_x = 575, 629 (clamped), 629, 373. No wrap.
- Truncation: dx = −1 ×10 at SHIFT = 1 → pos_x stays 320. dx = −3 → pos_x = 319.
- Recentre: move to (600, 400); send btn = 3 three times with dx = +50 → pos after reports 1 and 2 moves (clamped). Report 3 gives pos = (320, 240) exactly. A btn = 3,3,1,3 sequence never recentres.
- Off-board and click: move to X = 50; btn 0 → 1 → 1 → in_board_o = 0, cell_x = 0; click_o pulses on the first report only, each time coincident with valid_o.
- Busy/overrun/reset: valid_i on the cycle after accept → drop_o = 1, pos reflects only the first report. Assert rst_p during CELL → no valid_o, pos = (320, 240) next cycle.

Source files
------------

// File: rtl/cursor_accum_if.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_accum_if
//  Description : Report-in / cursor-out bundle between the PS/2 mouse decoder,
//                the cursor accumulator and the game/draw logic.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cursor_accum_if #(
    parameter int DW = 9,
    parameter int PW = 10,
    parameter int CW = 4
);
    logic                 valid_i;
    logic signed [DW-1:0] dx_i;
    logic signed [DW-1:0] dy_i;
    logic [7:0]           btn_i;
    logic [PW-1:0]        pos_x;
    logic [PW-1:0]        pos_y;
    logic [CW-1:0]        cell_x;
    logic [CW-1:0]        cell_y;
    logic                 in_board_o;
    logic                 click_o;
    logic [7:0]           btn_o;
    logic                 valid_o;
    logic                 drop_o;

    // Report source side (mouse decoder / testbench)
    modport master (
        output valid_i, dx_i, dy_i, btn_i,
        input  pos_x, pos_y, cell_x, cell_y, in_board_o, click_o, btn_o,
               valid_o, drop_o
    );

    // Accumulator side
    modport slave (
        input  valid_i, dx_i, dy_i, btn_i,
        output pos_x, pos_y, cell_x, cell_y, in_board_o, click_o, btn_o,
               valid_o, drop_o
    );
endinterface
`default_nettype wire

// File: rtl/cursor_accum.sv
`default_nettype none
// ============================================================================
//  Module      : cursor_accum
//  Description : Turns signed relative mouse reports into a clamped absolute
//                cursor, with long-hold recentre and a Gobang board-cell
//                lookup done by iterative subtraction (one step per cycle).
//  Revision    : 1.0 - initial release
// ============================================================================
module cursor_accum #(
    parameter int DW           = 9,
    parameter int PW           = 10,
    parameter int X_START      = 320,
    parameter int Y_START      = 240,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 629,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 469,
    parameter int SHIFT        = 1,
    parameter int RECENTER_BTN = 3,
    parameter int HOLD_CNT     = 3,
    parameter int BOARD_X0     = 95,
    parameter int BOARD_Y0     = 15,
    parameter int CELL         = 30,
    parameter int N_CELLS      = 15
) (
    input wire logic        clk,
    input wire logic        rst_p,
    cursor_accum_if.slave   bus
);
    localparam int c_cw = $clog2(N_CELLS);
    localparam int c_nw = PW + 2;
    localparam int c_hw = $clog2(HOLD_CNT + 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_acc  = 2'd1;
    localparam logic [1:0] c_st_cell = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic signed [c_nw-1:0] c_xmin = c_nw'(X_MIN);
    localparam logic signed [c_nw-1:0] c_xmax = c_nw'(X_MAX);
    localparam logic signed [c_nw-1:0] c_ymin = c_nw'(Y_MIN);
    localparam logic signed [c_nw-1:0] c_ymax = c_nw'(Y_MAX);
    localparam logic [PW-1:0]   c_xstart = PW'(X_START);
    localparam logic [PW-1:0]   c_ystart = PW'(Y_START);
    localparam logic [PW-1:0]   c_bx0    = PW'(BOARD_X0);
    localparam logic [PW-1:0]   c_by0    = PW'(BOARD_Y0);
    localparam logic [PW-1:0]   c_cell   = PW'(CELL);
    localparam logic [PW-1:0]   c_span   = PW'(CELL * N_CELLS);
    localparam logic [7:0]      c_rc_btn = 8'(RECENTER_BTN);
    localparam logic [c_hw-1:0] c_hold   = c_hw'(HOLD_CNT);

    // sign(d) * (|d| >> SHIFT); one extra bit so |-2^(DW-1)| fits
    function automatic logic signed [DW:0] f_scale(input logic signed [DW-1:0] d);
        logic signed [DW:0] w_ext;
        logic signed [DW:0] w_mag;
        logic signed [DW:0] w_shr;
        w_ext = {d[DW-1], d};
        w_mag = d[DW-1] ? -w_ext : w_ext;
        w_shr = w_mag >> SHIFT;
        return d[DW-1] ? -w_shr : w_shr;
    endfunction

    // pos + scaled in PW+2 signed bits, then clamped into [lo, hi]
    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p,
                                             input logic signed [DW-1:0] d,
                                             input logic signed [c_nw-1:0] lo,
                                             input logic signed [c_nw-1:0] hi);
        logic signed [DW:0]     w_s;
        logic signed [c_nw-1:0] w_sum;
        w_s   = f_scale(d);
        w_sum = $signed({2'b00, p}) + $signed({{(c_nw-DW-1){w_s[DW]}}, w_s});
        if (w_sum < lo)      return lo[PW-1:0];
        else if (w_sum > hi) return hi[PW-1:0];
        else                 return w_sum[PW-1:0];
    endfunction

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic signed [DW-1:0] r_dx;
    logic signed [DW-1:0] r_dy;
    logic [7:0]           r_btn_cap;
    logic                 r_click_cap;
    logic                 r_prev_btn0;
    logic [c_hw-1:0]      r_hold;
    logic                 r_recenter;
    logic [PW-1:0]        r_pos_x;
    logic [PW-1:0]        r_pos_y;
    logic [PW-1:0]        r_rel_x;
    logic [PW-1:0]        r_rel_y;
    logic [c_cw-1:0]      r_cnt_x;
    logic [c_cw-1:0]      r_cnt_y;
    logic                 r_done_x;
    logic                 r_done_y;
    logic                 r_inb_x;
    logic                 r_inb_y;
    logic [c_cw-1:0]      r_cell_x;
    logic [c_cw-1:0]      r_cell_y;
    logic                 r_in_board;
    logic [7:0]           r_btn_o;
    logic                 r_valid;
    logic                 r_click;

    logic [PW-1:0]   w_nx;
    logic [PW-1:0]   w_ny;
    logic [PW-1:0]   w_relx0;
    logic [PW-1:0]   w_rely0;
    logic            w_inbx0;
    logic            w_inby0;
    logic            w_fin_x;
    logic            w_fin_y;
    logic [c_hw-1:0] w_hold_inc;

    // Candidate position and initial board-relative offsets for the ACC cycle
    always_comb begin
        w_nx       = r_recenter ? c_xstart : f_next(r_pos_x, r_dx, c_xmin, c_xmax);
        w_ny       = r_recenter ? c_ystart : f_next(r_pos_y, r_dy, c_ymin, c_ymax);
        w_relx0    = w_nx - c_bx0;
        w_rely0    = w_ny - c_by0;
        w_inbx0    = (w_nx >= c_bx0) && (w_relx0 < c_span);
        w_inby0    = (w_ny >= c_by0) && (w_rely0 < c_span);
        w_fin_x    = r_done_x || !r_inb_x || (r_rel_x < c_cell);
        w_fin_y    = r_done_y || !r_inb_y || (r_rel_y < c_cell);
        w_hold_inc = r_hold + c_hw'(1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_p) r_state <= c_st_idle;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (bus.valid_i) w_state_nxt = c_st_acc;
            c_st_acc:  w_state_nxt = c_st_cell;
            c_st_cell: if (w_fin_x && w_fin_y) w_state_nxt = c_st_done;
            c_st_done: w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    // Datapath: capture, accumulate, cell iteration and output registers
    always_ff @(posedge clk) begin
        if (rst_p) begin
            r_dx        <= '0;
            r_dy        <= '0;
            r_btn_cap   <= '0;
            r_click_cap <= 1'b0;
            r_prev_btn0 <= 1'b0;
            r_hold      <= '0;
            r_recenter  <= 1'b0;
            r_pos_x     <= c_xstart;
            r_pos_y     <= c_ystart;
            r_rel_x     <= '0;
            r_rel_y     <= '0;
            r_cnt_x     <= '0;
            r_cnt_y     <= '0;
            r_done_x    <= 1'b0;
            r_done_y    <= 1'b0;
            r_inb_x     <= 1'b0;
            r_inb_y     <= 1'b0;
            r_cell_x    <= '0;
            r_cell_y    <= '0;
            r_in_board  <= 1'b0;
            r_btn_o     <= '0;
            r_valid     <= 1'b0;
            r_click     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_click <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (bus.valid_i) begin
                        r_dx        <= bus.dx_i;
                        r_dy        <= bus.dy_i;
                        r_btn_cap   <= bus.btn_i;
                        r_click_cap <= bus.btn_i[0] & ~r_prev_btn0;
                        r_prev_btn0 <= bus.btn_i[0];
                        // Reaching the hold count recentres and restarts counting
                        if (bus.btn_i == c_rc_btn) begin
                            if (w_hold_inc == c_hold) begin
                                r_hold     <= '0;
                                r_recenter <= 1'b1;
                            end else begin
                                r_hold     <= w_hold_inc;
                                r_recenter <= 1'b0;
                            end
                        end else begin
                            r_hold     <= '0;
                            r_recenter <= 1'b0;
                        end
                    end
                end
                c_st_acc: begin
                    r_pos_x  <= w_nx;
                    r_pos_y  <= w_ny;
                    r_rel_x  <= w_relx0;
                    r_rel_y  <= w_rely0;
                    r_inb_x  <= w_inbx0;
                    r_inb_y  <= w_inby0;
                    r_cnt_x  <= '0;
                    r_cnt_y  <= '0;
                    r_done_x <= 1'b0;
                    r_done_y <= 1'b0;
                end
                c_st_cell: begin
                    // Off-board axes finish immediately with a zero count
                    if (!r_done_x) begin
                        if (!r_inb_x || r_rel_x < c_cell) begin
                            r_done_x <= 1'b1;
                        end else begin
                            r_rel_x <= r_rel_x - c_cell;
                            r_cnt_x <= r_cnt_x + c_cw'(1);
                        end
                    end
                    if (!r_done_y) begin
                        if (!r_inb_y || r_rel_y < c_cell) begin
                            r_done_y <= 1'b1;
                        end else begin
                            r_rel_y <= r_rel_y - c_cell;
                            r_cnt_y <= r_cnt_y + c_cw'(1);
                        end
                    end
                end
                c_st_done: begin
                    r_valid    <= 1'b1;
                    r_click    <= r_click_cap;
                    r_btn_o    <= r_btn_cap;
                    r_cell_x   <= r_cnt_x;
                    r_cell_y   <= r_cnt_y;
                    r_in_board <= r_inb_x & r_inb_y;
                end
                default: ;
            endcase
        end
    end

    assign bus.pos_x      = r_pos_x;
    assign bus.pos_y      = r_pos_y;
    assign bus.cell_x     = r_cell_x;
    assign bus.cell_y     = r_cell_y;
    assign bus.in_board_o = r_in_board;
    assign bus.click_o    = r_click;
    assign bus.btn_o      = r_btn_o;
    assign bus.valid_o    = r_valid;
    // A report arriving while the pipeline is busy is discarded and flagged
    assign bus.drop_o     = bus.valid_i && (r_state != c_st_idle) && !rst_p;
endmodule
`default_nettype wire

// File: tb/tb_cursor_accum.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cursor_accum
//  Description : Scoreboard bench for cursor_accum with directed reports and
//                hand-computed expected cursor/cell/click results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cursor_accum;
    logic clk;
    logic rst_p;

    cursor_accum_if #(.DW(9), .PW(10), .CW(4)) bus ();

    cursor_accum dut (
        .clk   (clk),
        .rst_p (rst_p),
        .bus   (bus)
    );

    typedef struct {
        int px;
        int py;
        int cx;
        int cy;
        int inb;
        int ck;
        int btn;
    } exp_t;

    exp_t q_exp[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every valid_o pulse is checked against the oldest expectation
    always @(negedge clk) begin
        if (!rst_p && bus.valid_o) begin
            if (q_exp.size() == 0) begin
                chk("unexpected_valid_o", 1, 0);
            end else begin
                exp_t e;
                e = q_exp.pop_front();
                chk("pos_x",    int'(bus.pos_x),      e.px);
                chk("pos_y",    int'(bus.pos_y),      e.py);
                chk("cell_x",   int'(bus.cell_x),     e.cx);
                chk("cell_y",   int'(bus.cell_y),     e.cy);
                chk("in_board", int'(bus.in_board_o), e.inb);
                chk("click",    int'(bus.click_o),    e.ck);
                chk("btn_o",    int'(bus.btn_o),      e.btn);
            end
        end
    end

    // Issue one report at the current negedge; optionally overrun it next cycle
    task automatic send(input int dx, input int dy, input int btn,
                        input int px, input int py, input int cx, input int cy,
                        input int inb, input int ck, input int lat,
                        input bit overrun = 1'b0);
        int got_lat;
        exp_t e;
        e = '{px: px, py: py, cx: cx, cy: cy, inb: inb, ck: ck, btn: btn};
        q_exp.push_back(e);
        bus.dx_i    = 9'(dx);
        bus.dy_i    = 9'(dy);
        bus.btn_i   = 8'(btn);
        bus.valid_i = 1'b1;
        #1 chk("drop_on_accept", int'(bus.drop_o), 0);
        got_lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.valid_o) begin
                got_lat = i;
                break;
            end
            if (i == 1) begin
                if (overrun) begin
                    bus.dx_i = 9'(200);
                    #1 chk("drop_on_overrun", int'(bus.drop_o), 1);
                end else begin
                    bus.valid_i = 1'b0;
                end
            end
            if (i == 2) bus.valid_i = 1'b0;
        end
        chk("latency", got_lat, lat);
    endtask

    initial begin
        int seen;
        rst_p       = 1'b1;
        bus.valid_i = 1'b0;
        bus.dx_i    = '0;
        bus.dy_i    = '0;
        bus.btn_i   = '0;
        repeat (3) @(negedge clk);
        rst_p = 1'b0;
        #1;
        chk("rst_pos_x",    int'(bus.pos_x), 320);
        chk("rst_pos_y",    int'(bus.pos_y), 240);
        chk("rst_cell_x",   int'(bus.cell_x), 0);
        chk("rst_cell_y",   int'(bus.cell_y), 0);
        chk("rst_in_board", int'(bus.in_board_o), 0);
        chk("rst_valid",    int'(bus.valid_o), 0);
        chk("rst_click",    int'(bus.click_o), 0);
        chk("rst_btn_o",    int'(bus.btn_o), 0);
        @(negedge clk);

        //     dx    dy   btn   px   py  cx  cy inb ck lat
        send(  20,  -10,  0,  330, 235,  7,  7, 1, 0, 11);
        for (int i = 0; i < 4; i++)
            send(-1, -1,   0,  330, 235,  7,  7, 1, 0, 11);
        send(  -3,    3,  0,  329, 236,  7,  7, 1, 0, 11);
        // Extreme deltas and clamping
        send( 255,    0,  0,  456, 236, 12,  7, 1, 0, 16);
        send( 255,    0,  0,  583, 236,  0,  7, 0, 0, 11);
        send( 255,    0,  0,  629, 236,  0,  7, 0, 0, 11);
        send(-256,    0,  0,  501, 236, 13,  7, 1, 0, 17);
        send(   0, -256,  0,  501, 108, 13,  3, 1, 0, 17);
        send(   0, -256,  0,  501,   0, 13,  0, 0, 0, 17);
        send( 198,  255,  0,  600, 127,  0,  3, 0, 0,  7);
        send(   0,  255,  0,  600, 254,  0,  7, 0, 0, 11);
        // Long hold recentre
        send(  50,   50,  3,  625, 279,  0,  8, 0, 1, 12);
        send(  50,   50,  3,  629, 304,  0,  9, 0, 0, 13);
        send(  50,   50,  3,  320, 240,  7,  7, 1, 0, 11);
        // Interrupted hold never recentres
        send(   2,    0,  3,  321, 240,  7,  7, 1, 0, 11);
        send(   2,    0,  3,  322, 240,  7,  7, 1, 0, 11);
        send(   2,    0,  1,  323, 240,  7,  7, 1, 0, 11);
        send(   2,    0,  3,  324, 240,  7,  7, 1, 0, 11);
        // Off board and click edge
        send(-256,    0,  0,  196, 240,  3,  7, 1, 0, 11);
        send(-256,    0,  0,   68, 240,  0,  7, 0, 0, 11);
        send( -36,    0,  0,   50, 240,  0,  7, 0, 0, 11);
        send(   0,    0,  1,   50, 240,  0,  7, 0, 1, 11);
        send(   0,    0,  1,   50, 240,  0,  7, 0, 0, 11);
        // Both axes off board: shortest latency
        send(   0,  255,  0,   50, 367,  0, 11, 1'b0, 0, 15);
        send(   0,  255,  0,   50, 469,  0,  0, 0, 0,  4);
        // Overrun: second report dropped
        send( 100, -100,  0,  100, 419,  0, 13, 1, 0, 17, 1'b1);

        // Reset while the cell lookup is running
        bus.dx_i    = 9'(20);
        bus.dy_i    = '0;
        bus.btn_i   = '0;
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_p = 1'b1;
        @(negedge clk);
        rst_p = 1'b0;
        #1;
        chk("midrst_pos_x",    int'(bus.pos_x), 320);
        chk("midrst_pos_y",    int'(bus.pos_y), 240);
        chk("midrst_in_board", int'(bus.in_board_o), 0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.valid_o) seen = 1;
        end
        chk("midrst_no_valid", seen, 0);

        // Recovery after reset; click edge relies on cleared previous button
        send(  20,  -10,  1,  330, 235,  7,  7, 1, 1, 11);

        repeat (5) @(negedge clk);
        chk("queue_empty", q_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
